// File: rtl/serial_pattern_fsm_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package serial_pattern_fsm_pkg;

  localparam int FILL_W    = 5;
  localparam int MAX_PAT_W = 16;

  typedef enum logic [0:0] {
    DET_FLUSH   = 1'b0,
    DET_OVERLAP = 1'b1
  } det_mode_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
    logic [31:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_pattern_fsm_if.sv
// Serial bit source / match consumer bundle. Macro PATTERN_PROG_EN adds pattern load signals.
interface serial_pattern_fsm_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic                                  xin_valid;
  logic                                  xin;
  logic                                  xout;
  logic [CNT_W-1:0]                      match_cnt;
  logic [serial_pattern_fsm_pkg::FILL_W-1:0] fill;
`ifdef PATTERN_PROG_EN
  logic                                  pat_load;
  logic [PAT_W-1:0]                      pat_in;

  modport master (output xin_valid, xin, pat_load, pat_in, input xout, match_cnt, fill);
  modport slave  (input xin_valid, xin, pat_load, pat_in, output xout, match_cnt, fill);
`else
  modport master (output xin_valid, xin, input xout, match_cnt, fill);
  modport slave  (input xin_valid, xin, output xout, match_cnt, fill);
`endif
endinterface

// File: rtl/serial_pattern_fsm_hist_reg.sv
// History shift register with saturating fill count; clear wins over shift enable.
module serial_hist_reg
  import serial_pattern_fsm_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [PAT_W-1:0]  hist_nxt,
  output logic [FILL_W-1:0] fill,
  output logic [FILL_W-1:0] fill_nxt
);

  logic [PAT_W-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;

  // Candidate state if the current bit is accepted
  always_comb begin
    hist_nxt = {hist_r[PAT_W-2:0], din};
    fill_nxt = FILL_W'(sat_inc(32'(fill_r), 32'(PAT_W)));
  end

  // History and fill registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (clr) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (en) begin
      hist_r <= hist_nxt;
      fill_r <= fill_nxt;
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  assign fill = fill_r;

endmodule

// File: rtl/serial_pattern_fsm.sv
// Serial sequence detector: one-cycle match pulse plus saturating match counter.
// Macro PATTERN_PROG_EN enables a runtime-loadable pattern register.
module serial_pattern_fsm
  import serial_pattern_fsm_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_pattern_fsm_if.slave  bus
);

  localparam det_mode_e   MODE    = (OVERLAP != 0) ? DET_OVERLAP : DET_FLUSH;
  localparam logic [31:0] CNT_LIM = 32'((64'd1 << CNT_W) - 64'd1);

  logic [PAT_W-1:0]  hist_nxt_s;
  logic [PAT_W-1:0]  pattern_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [FILL_W-1:0] fill_s;
  logic              load_s;
  logic              match_s;
  logic              clear_s;
  logic              xout_r;
  logic [CNT_W-1:0]  cnt_r;

`ifdef PATTERN_PROG_EN
  logic [PAT_W-1:0] pattern_r;

  // Active pattern, reloadable at runtime
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_r <= PATTERN;
    end else if (bus.pat_load) begin
      pattern_r <= bus.pat_in;
    end else begin
      pattern_r <= pattern_r;
    end
  end

  assign load_s    = bus.pat_load;
  assign pattern_s = pattern_r;
`else
  assign load_s    = 1'b0;
  assign pattern_s = PATTERN;
`endif

  serial_hist_reg #(.PAT_W(PAT_W)) u_hist (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.xin_valid),
    .clr      (clear_s),
    .din      (bus.xin),
    .hist_nxt (hist_nxt_s),
    .fill     (fill_s),
    .fill_nxt (fill_nxt_s)
  );

  // Match on the accepted bit; a load drops that bit, flush mode restarts history
  always_comb begin
    match_s = 1'b0;
    clear_s = 1'b0;
    if (load_s) begin
      clear_s = 1'b1;
    end else if (bus.xin_valid && (fill_nxt_s == FILL_W'(PAT_W)) && (hist_nxt_s == pattern_s)) begin
      match_s = 1'b1;
      clear_s = (MODE == DET_FLUSH);
    end else begin
      match_s = 1'b0;
    end
  end

  // Registered match pulse and saturating counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xout_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      xout_r <= match_s;
      if (match_s) begin
        cnt_r <= CNT_W'(sat_inc(32'(cnt_r), CNT_LIM));
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.xout      = xout_r;
  assign bus.match_cnt = cnt_r;
  assign bus.fill      = fill_s;

endmodule
